// File: rtl/mac_dot_pipe.sv
// mac_dot_pipe: pipelined signed fixed-point dot-product engine.
// Elements stream in through a valid/ready handshake. Each one runs through
// three stages: operand register, full-width product, accumulate. A vector
// closes on in_last or on its LEN-th element. The accumulated sum is then
// scaled back to the input Q format and held until the consumer takes it.
// Optional build macro: MAC_DOT_SATURATE_EN clamps the result on overflow.
// Without it, the result wraps around to DATA_W bits.
module mac_dot_pipe #(
   parameter int DATA_W = 16,
   parameter int FRAC_W = 9,
   parameter int ACC_W  = 40,
   parameter int LEN    = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [DATA_W-1:0]          a,
   input  logic [DATA_W-1:0]          b,
   input  logic                       in_last,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [DATA_W-1:0]          result,
   output logic                       overflow,
   output logic [$clog2(LEN+1)-1:0]   count
);

   localparam int CNT_W = $clog2(LEN+1);
   localparam int PROD_W = 2*DATA_W;
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(LEN-1);

   typedef enum logic [1:0] {ACCUM, DRAIN, HOLD} state_t;

   state_t state, next_state;

   logic                     accept;
   logic                     vec_end;
   logic                     drain_done;
   logic                     handshake;
   logic [1:0]               drain_cnt;
   logic [CNT_W-1:0]         elem_cnt;

   logic                     v1, v2;
   logic signed [DATA_W-1:0] a_r, b_r;
   logic signed [PROD_W-1:0] a_ext, b_ext;
   logic signed [PROD_W-1:0] prod_r;
   logic signed [ACC_W-1:0]  acc;

   logic signed [ACC_W-1:0]  scaled;
   logic [ACC_W-DATA_W:0]    sign_bits;
   logic                     ovf_next;
   logic [DATA_W-1:0]        res_next;

   // State register.
   always_ff @(posedge clk) begin
      if (reset)
         state <= ACCUM;
      else
         state <= next_state;
   end

   // Next state: leave ACCUM when the vector closes, spend three cycles in DRAIN,
   // and wait in HOLD until the consumer takes the result.
   always_comb begin
      next_state = state;
      case (state)
         ACCUM:   if (vec_end)    next_state = DRAIN;
         DRAIN:   if (drain_done) next_state = HOLD;
         HOLD:    if (handshake)  next_state = ACCUM;
         default:                 next_state = ACCUM;
      endcase
   end

   // FSM outputs and the handshake qualifiers derived from the state.
   always_comb begin
      in_ready   = (state == ACCUM) && !reset;
      accept     = in_valid && in_ready;
      vec_end    = accept && (in_last || (elem_cnt == LAST_IDX));
      drain_done = (state == DRAIN) && (drain_cnt == 2'd2);
      handshake  = out_valid && out_ready;
   end

   // DRAIN lasts exactly three cycles, which lets the last element pass through S2 and S3.
   always_ff @(posedge clk) begin
      if (reset || (state != DRAIN))
         drain_cnt <= 2'd0;
      else
         drain_cnt <= drain_cnt + 2'd1;
   end

   // Count the accepted elements of the current vector.
   always_ff @(posedge clk) begin
      if (reset || handshake)
         elem_cnt <= '0;
      else if (accept)
         elem_cnt <= elem_cnt + 1'b1;
   end

   // Sign-extend the operands so the product is computed at full 2*DATA_W width.
   always_comb begin
      a_ext = {{DATA_W{a_r[DATA_W-1]}}, a_r};
      b_ext = {{DATA_W{b_r[DATA_W-1]}}, b_r};
   end

   // Three-stage datapath: register the operands, the product, then accumulate.
   always_ff @(posedge clk) begin
      if (reset || handshake) begin
         v1     <= 1'b0;
         v2     <= 1'b0;
         a_r    <= '0;
         b_r    <= '0;
         prod_r <= '0;
         acc    <= '0;
      end else begin
         v1 <= accept;
         v2 <= v1;
         if (accept) begin
            a_r <= a;
            b_r <= b;
         end
         if (v1)
            prod_r <= a_ext * b_ext;
         if (v2)
            acc <= acc + {{(ACC_W-PROD_W){prod_r[PROD_W-1]}}, prod_r};
      end
   end

   // Scale back to the input format with a flooring shift. Detect an overflow when the
   // bits above the result are not a plain sign extension, and choose wrap or clamp.
   always_comb begin
      scaled    = acc >>> FRAC_W;
      sign_bits = scaled[ACC_W-1:DATA_W-1];
      ovf_next  = !((&sign_bits) || !(|sign_bits));
`ifdef MAC_DOT_SATURATE_EN
      if (ovf_next)
         res_next = scaled[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}}
                                    : {1'b0, {(DATA_W-1){1'b1}}};
      else
         res_next = scaled[DATA_W-1:0];
`else
      res_next = scaled[DATA_W-1:0];
`endif
   end

   // Output register: load on the last DRAIN edge and hold until the handshake.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid <= 1'b0;
         result    <= '0;
         overflow  <= 1'b0;
         count     <= '0;
      end else if (drain_done) begin
         out_valid <= 1'b1;
         result    <= res_next;
         overflow  <= ovf_next;
         count     <= elem_cnt;
      end else if (handshake) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mac_dot_pipe.sv
// tb_mac_dot_pipe: self-checking bench for mac_dot_pipe at its default parameters.
// The bench drives directed vectors and randomized vectors. Every result is compared
// against a behavioural dot-product model built on integer arithmetic.
module tb_mac_dot_pipe;

   localparam int DATA_W = 16;
   localparam int FRAC_W = 9;
   localparam int ACC_W  = 40;
   localparam int LEN    = 8;
   localparam int CNT_W  = $clog2(LEN+1);

   logic              clk = 1'b0;
   logic              reset;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] a;
   logic [DATA_W-1:0] b;
   logic              in_last;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] result;
   logic              overflow;
   logic [CNT_W-1:0]  count;

   int assertCount = 0;
   int failCount   = 0;

   logic [DATA_W-1:0] va [LEN];
   logic [DATA_W-1:0] vb [LEN];

   mac_dot_pipe #(
      .DATA_W (DATA_W),
      .FRAC_W (FRAC_W),
      .ACC_W  (ACC_W),
      .LEN    (LEN)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .overflow  (overflow),
      .count     (count)
   );

   // Free-running clock with a 10-unit period.
   always #5 clk = ~clk;

   // Single comparison point: count the check and report any mismatch.
   task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      assertCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   // Reference model: exact integer dot product, floor division by 2^FRAC_W,
   // then a range test and a wrap or clamp into DATA_W bits.
   task automatic computeExpected(input int n, output logic [DATA_W-1:0] expRes, output logic expOvf);
      longint sum;
      longint scaled;
      longint maxVal;
      longint minVal;
      sum = 0;
      for (int i = 0; i < n; i++)
         sum += longint'($signed(va[i])) * longint'($signed(vb[i]));
      scaled = sum >>> FRAC_W;
      maxVal = (longint'(1) << (DATA_W-1)) - 1;
      minVal = -(longint'(1) << (DATA_W-1));
      expOvf = (scaled > maxVal) || (scaled < minVal);
`ifdef MAC_DOT_SATURATE_EN
      if (expOvf)
         expRes = (scaled < 0) ? 16'h8000 : 16'h7FFF;
      else
         expRes = scaled[DATA_W-1:0];
`else
      expRes = scaled[DATA_W-1:0];
`endif
   endtask

   // Drive va/vb[0..n-1] as one vector, check latency and results against the model,
   // hold off the consumer for holdCycles, then complete the handshake (holdCycles < 0 leaves it in HOLD).
   task automatic applyStimulus(input string tag, input int n, input bit useLast,
                                input int holdCycles, input bit bubbles);
      logic [DATA_W-1:0] expRes;
      logic              expOvf;
      int                cycles;
      computeExpected(n, expRes, expOvf);
      for (int i = 0; i < n; i++) begin
         if (bubbles && ($urandom_range(0, 2) == 0)) begin
            @(negedge clk);
            in_valid = 1'b0;
            checkOutput({tag, ".ready_idle"}, 64'(in_ready), 64'd1);
         end
         @(negedge clk);
         checkOutput({tag, ".ready_accum"}, 64'(in_ready), 64'd1);
         in_valid = 1'b1;
         a        = va[i];
         b        = vb[i];
         in_last  = useLast && (i == n-1);
      end
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
      a        = DATA_W'($urandom);
      b        = DATA_W'($urandom);
      checkOutput({tag, ".ready_drain"}, 64'(in_ready), 64'd0);
      cycles = 0;
      while (!out_valid && (cycles < 20)) begin
         @(negedge clk);
         cycles++;
      end
      checkOutput({tag, ".latency"}, 64'(cycles), 64'd3);
      checkOutput({tag, ".result"}, 64'(result), 64'(expRes));
      checkOutput({tag, ".overflow"}, 64'(overflow), 64'(expOvf));
      checkOutput({tag, ".count"}, 64'(count), 64'(n));
      if (holdCycles >= 0) begin
         for (int h = 0; h < holdCycles; h++) begin
            @(negedge clk);
            checkOutput({tag, ".hold_valid"}, 64'(out_valid), 64'd1);
            checkOutput({tag, ".hold_result"}, 64'(result), 64'(expRes));
            checkOutput({tag, ".hold_count"}, 64'(count), 64'(n));
            checkOutput({tag, ".hold_ready"}, 64'(in_ready), 64'd0);
         end
         out_ready = 1'b1;
         @(negedge clk);
         out_ready = 1'b0;
         checkOutput({tag, ".post_valid"}, 64'(out_valid), 64'd0);
         checkOutput({tag, ".post_ready"}, 64'(in_ready), 64'd1);
      end
   endtask

   // Pulse reset for one cycle and confirm every output clears and input reopens.
   task automatic pulseReset(input string tag);
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
      reset    = 1'b1;
      @(negedge clk);
      checkOutput({tag, ".rst_ready"}, 64'(in_ready), 64'd0);
      checkOutput({tag, ".rst_valid"}, 64'(out_valid), 64'd0);
      checkOutput({tag, ".rst_result"}, 64'(result), 64'd0);
      checkOutput({tag, ".rst_overflow"}, 64'(overflow), 64'd0);
      checkOutput({tag, ".rst_count"}, 64'(count), 64'd0);
      reset = 1'b0;
      @(negedge clk);
      checkOutput({tag, ".rst_ready_after"}, 64'(in_ready), 64'd1);
   endtask

   // Draw an operand: usually a modest value, sometimes a full-range one.
   function automatic logic [DATA_W-1:0] randOperand();
      logic [DATA_W-1:0] v;
      if ($urandom_range(0, 3) == 0)
         v = DATA_W'($urandom);
      else
         v = DATA_W'($urandom_range(0, 16'h0800)) - 16'h0400;
      return v;
   endfunction

   // Bound the run so the bench terminates even if the design locks up.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // Main sequence: reset, directed vectors, resets mid-flight, then random vectors.
   initial begin
      int n;
      bit useLast;
      reset     = 1'b1;
      in_valid  = 1'b0;
      in_last   = 1'b0;
      out_ready = 1'b0;
      a         = '0;
      b         = '0;

      @(negedge clk);
      @(negedge clk);
      checkOutput("reset.ready", 64'(in_ready), 64'd0);
      checkOutput("reset.valid", 64'(out_valid), 64'd0);
      checkOutput("reset.result", 64'(result), 64'd0);
      checkOutput("reset.overflow", 64'(overflow), 64'd0);
      checkOutput("reset.count", 64'(count), 64'd0);
      reset = 1'b0;
      @(negedge clk);
      checkOutput("reset.ready_after", 64'(in_ready), 64'd1);

      for (int i = 0; i < LEN; i++) begin va[i] = 16'h0200; vb[i] = 16'hFE00; end
      applyStimulus("full", LEN, 1'b1, 0, 1'b0);
      checkOutput("full.const_result", 64'(dut.result), 64'hF000);

      for (int i = 0; i < LEN; i++) begin va[i] = 16'h7FFF; vb[i] = 16'h7FFF; end
      applyStimulus("overflow", LEN, 1'b0, 0, 1'b0);

      for (int i = 0; i < 3; i++) begin va[i] = 16'h0400; vb[i] = 16'h0300; end
      applyStimulus("early", 3, 1'b1, 0, 1'b0);

      va[0] = 16'h0001; vb[0] = 16'hFFFF;
      applyStimulus("floor", 1, 1'b1, 0, 1'b0);

      for (int i = 0; i < 3; i++) begin va[i] = 16'h0400; vb[i] = 16'h0300; end
      applyStimulus("backpressure", 3, 1'b1, 5, 1'b0);
      va[0] = 16'h0200; vb[0] = 16'h0200;
      applyStimulus("after_bp", 1, 1'b1, 0, 1'b0);

      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checkOutput("midreset.ready", 64'(in_ready), 64'd1);
         in_valid = 1'b1;
         in_last  = 1'b0;
         a        = 16'h1234;
         b        = 16'h0777;
      end
      pulseReset("midreset");
      for (int i = 0; i < LEN; i++) begin va[i] = 16'h0200; vb[i] = 16'hFE00; end
      applyStimulus("full_again", LEN, 1'b1, 0, 1'b0);

      applyStimulus("held", LEN, 1'b1, -1, 1'b0);
      pulseReset("holdreset");
      va[0] = 16'h0400; vb[0] = 16'h0400;
      applyStimulus("after_hold_reset", 1, 1'b1, 0, 1'b0);

      for (int t = 0; t < 25; t++) begin
         n = $urandom_range(1, LEN);
         useLast = (n < LEN) ? 1'b1 : 1'($urandom_range(0, 1));
         for (int i = 0; i < LEN; i++) begin
            va[i] = randOperand();
            vb[i] = randOperand();
         end
         applyStimulus($sformatf("rand%0d", t), n, useLast, $urandom_range(0, 3), 1'b1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
